arm_dp_issue: RTL and testbench
===============================

# arm_dp_issue

Issue/writeback sequencer for the ARM ALU: accepts one 32-bit ARM data-processing instruction plus its register operands, evaluates the condition field against the architectural NZCV register, and drives the ALU's A/B/OP/S/FLAGS inputs. It then captures the ALU result and flags, updates NZCV when S is set, and issues one register-file writeback. It sits between the fetch/decode front end and the ALU/register file and owns the CPSR flag bits.

## Interface
- EXEC_CYCLES, 1: cycles the ALU inputs are held before result/flags capture; legal 1..4.
- CLK  input  1  clock; all state on rising edge
- RESET_N  input  1  reset, synchronous, active-low
- INSTR  input  32  ARM instruction word
- RN_DATA  input  32  value of Rn, sampled with INSTR
- RM_DATA  input  32  value of Rm, sampled with INSTR
- INSTR_VALID  input  1  INSTR/RN_DATA/RM_DATA valid
- INSTR_READY  output  1  block can accept; reset 1
- ALU_A  output  32  ALU operand A (Rn); reset 0
- ALU_B  output  32  ALU operand B (shifter operand); reset 0
- ALU_OP  output  5  ALU opcode; reset 5'b10000
- ALU_S  output  1  ALU flag-select; reset 0
- ALU_FLAGS  output  4  current NZCV to ALU; reset 0
- ALU_RESULT  input  32  ALU Out
- ALU_FLAGS_OUT  input  4  ALU FLAGS_OUT, {N,Z,C,V}
- FLAGS  output  4  architectural NZCV; reset 0
- WB_EN  output  1  register write strobe; reset 0
- WB_ADDR  output  4  destination Rd; reset 0
- WB_DATA  output  32  write data; reset 0
- DONE  output  1  one-cycle end-of-instruction pulse; reset 0
- SKIPPED  output  1  valid with DONE: condition failed; reset 0
- ILLEGAL  output  1  valid with DONE: unsupported encoding; reset 0

## Operation
- FSM: IDLE, EVAL, EXEC, WB. INSTR_READY=1 only in IDLE.
- IDLE: INSTR_VALID&INSTR_READY latches INSTR, RN_DATA, RM_DATA -> EVAL.
- EVAL (1 cycle): decode; legal iff INSTR[27:26]==00 and not (INSTR[25]==0 and INSTR[4]==1). Illegal -> DONE=1, ILLEGAL=1 next cycle, -> IDLE. Condition INSTR[31:28]: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never. Fail -> DONE=1, SKIPPED=1, -> IDLE, no flag/register change. Pass -> register ALU_A=Rn data, ALU_B, ALU_OP, ALU_S, ALU_FLAGS=FLAGS; -> EXEC.
- Opcode map INSTR[24:21]: 0-12 and 14 -> {1'b0,opc}; MOV(13) -> 5'b10000; MVN(15) -> 5'b10000 with ALU_B inverted.
- ALU_S=INSTR[20]; forced 1 for TST/TEQ/CMP/CMN (opc 8-11).
- Operand B: INSTR[25]=1 -> imm8 INSTR[7:0] (see Configuration); INSTR[25]=0 -> RM_DATA, shift field INSTR[11:4] ignored.
- EXEC: counter holds ALU inputs EXEC_CYCLES cycles; on last cycle capture ALU_RESULT into WB_DATA; if ALU_S, FLAGS<=ALU_FLAGS_OUT. -> WB.
- WB (1 cycle): DONE=1; WB_EN=1, WB_ADDR=INSTR[15:12] except opc 8-11 (WB_EN=0). -> IDLE.
- ALU outputs held stable from EVAL exit until next EVAL exit.

## Timing
- Accept edge = cycle 0; EVAL cycle 1; EXEC cycles 2..1+EXEC_CYCLES; WB/DONE in cycle 2+EXEC_CYCLES. Skip/illegal: DONE in cycle 2.
- Throughput: one instruction per 3+EXEC_CYCLES cycles; INSTR_READY rises the cycle after DONE... (IDLE entered edge after WB).
- FLAGS update visible in WB cycle; next instruction's condition uses updated FLAGS.
- RESET_N low any cycle: next edge -> IDLE, all outputs to reset values, FLAGS=0, in-flight instruction dropped, no WB_EN.
- INSTR_VALID while not ready: ignored, not latched.

## Configuration
- ARM_DP_ROTATE_IMM_EN defined: immediate operand = {24'b0,imm8} rotated right by 2*INSTR[11:8]; ALU_FLAGS C bit unaffected by rotate.
- Undefined: INSTR[11:8] ignored, operand = {24'b0,imm8}.

## Test plan
- Reset then MOV R1,#5 (0xE3A01005): ALU_OP=10000, ALU_B=5; WB_EN=1, WB_ADDR=1, WB_DATA=5 in cycle 3 (EXEC_CYCLES=1); FLAGS stay 0.
- SUBS R2,R0,R1 (0xE0502001), RN=5, RM=5: ALU_OP=00010, ALU_S=1; FLAGS=ALU_FLAGS_OUT (Z=1); then ADDEQ R3,R0,R1 executes, ADDNE skips (DONE+SKIPPED in cycle 2, no WB_EN).
- CMP R0,R1 (0xE1500001): ALU_OP=01010, ALU_S=1, FLAGS updated, WB_EN stays 0 in WB cycle.
- LDR (0xE5901000) -> DONE+ILLEGAL, FLAGS and writeback unchanged; MVN R4,R5 RM=0 -> WB_DATA=0xFFFFFFFF.
- With ARM_DP_ROTATE_IMM_EN: MOV R0,#0xFF rot 4 (0xE3A004FF) -> WB_DATA=0xFF000000; without -> 0x000000FF.
- RESET_N low during EXEC of ADDS: no WB_EN, FLAGS=0, INSTR_READY=1 next cycle.

Source files
------------

// File: rtl/arm_dp_issue.sv
// Issue/writeback sequencer for ARM data-processing instructions: condition check, ALU drive,
// NZCV ownership and one writeback. Define ARM_DP_ROTATE_IMM_EN to enable rotated immediates.
module arm_dp_issue #(
    parameter int EXEC_CYCLES = 1  // 1..4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rn_data,
    input  logic [31:0] i_rm_data,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [4:0]  o_alu_op,
    output logic        o_alu_s,
    output logic [3:0]  o_alu_flags,
    input  logic [31:0] i_alu_result,
    input  logic [3:0]  i_alu_flags_out,
    output logic [3:0]  o_flags,
    output logic        o_wb_en,
    output logic [3:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_done,
    output logic        o_skipped,
    output logic        o_illegal
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EXEC, S_WB} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_instr, r_rn, r_rm;
    logic [1:0]  r_cnt;

    logic [3:0]  w_opc;
    logic        w_cmp, w_legal, w_pass, w_last, w_s;
    logic [31:0] w_imm, w_opb_raw, w_opb;
    logic [4:0]  w_op;
    logic        w_n, w_z, w_c, w_v;
    logic        w_unused;

    assign w_opc   = r_instr[24:21];
    assign w_cmp   = (w_opc[3:2] == 2'b10);
    assign w_legal = (r_instr[27:26] == 2'b00) && !(!r_instr[25] && r_instr[4]);
    assign {w_n, w_z, w_c, w_v} = o_flags;
    assign w_last  = (r_cnt == 2'(EXEC_CYCLES - 1));
    assign w_s     = r_instr[20] | w_cmp;
    assign w_unused = ^{r_instr[19:16], r_instr[11:8], r_instr[3:0]};

`ifdef ARM_DP_ROTATE_IMM_EN
    logic [63:0] w_imm_dbl;
    // Doubling the word turns a right shift into a rotate.
    assign w_imm_dbl = {24'b0, r_instr[7:0], 24'b0, r_instr[7:0]} >> {r_instr[11:8], 1'b0};
    assign w_imm     = w_imm_dbl[31:0];
`else
    assign w_imm = {24'b0, r_instr[7:0]};
`endif

    assign w_opb_raw = r_instr[25] ? w_imm : r_rm;
    assign w_opb     = (w_opc == 4'd15) ? ~w_opb_raw : w_opb_raw;
    assign w_op      = (w_opc == 4'd13 || w_opc == 4'd15) ? 5'b10000 : {1'b0, w_opc};

    always_comb begin
        case (r_instr[31:28])
            4'h0:    w_pass = w_z;
            4'h1:    w_pass = !w_z;
            4'h2:    w_pass = w_c;
            4'h3:    w_pass = !w_c;
            4'h4:    w_pass = w_n;
            4'h5:    w_pass = !w_n;
            4'h6:    w_pass = w_v;
            4'h7:    w_pass = !w_v;
            4'h8:    w_pass = w_c && !w_z;
            4'h9:    w_pass = !w_c || w_z;
            4'hA:    w_pass = (w_n == w_v);
            4'hB:    w_pass = (w_n != w_v);
            4'hC:    w_pass = !w_z && (w_n == w_v);
            4'hD:    w_pass = w_z || (w_n != w_v);
            4'hE:    w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_instr_valid) w_next = S_EVAL;
            S_EVAL: w_next = (w_legal && w_pass) ? S_EXEC : S_IDLE;
            S_EXEC: if (w_last) w_next = S_WB;
            S_WB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_instr_ready = (r_state == S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_instr     <= '0;
            r_rn        <= '0;
            r_rm        <= '0;
            r_cnt       <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= 5'b10000;
            o_alu_s     <= 1'b0;
            o_alu_flags <= '0;
            o_flags     <= '0;
            o_wb_en     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_done      <= 1'b0;
            o_skipped   <= 1'b0;
            o_illegal   <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_skipped <= 1'b0;
            o_illegal <= 1'b0;
            o_wb_en   <= 1'b0;
            case (r_state)
                S_IDLE: if (i_instr_valid) begin
                    r_instr <= i_instr;
                    r_rn    <= i_rn_data;
                    r_rm    <= i_rm_data;
                end
                S_EVAL: begin
                    if (!w_legal) begin
                        o_done    <= 1'b1;
                        o_illegal <= 1'b1;
                    end else if (!w_pass) begin
                        o_done    <= 1'b1;
                        o_skipped <= 1'b1;
                    end else begin
                        o_alu_a     <= r_rn;
                        o_alu_b     <= w_opb;
                        o_alu_op    <= w_op;
                        o_alu_s     <= w_s;
                        o_alu_flags <= o_flags;
                        r_cnt       <= '0;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + 2'd1;
                    // DONE/WB strobes are registered here so they land in the WB cycle.
                    if (w_last) begin
                        o_wb_data <= i_alu_result;
                        if (o_alu_s) o_flags <= i_alu_flags_out;
                        o_done    <= 1'b1;
                        o_wb_en   <= !w_cmp;
                        o_wb_addr <= r_instr[15:12];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arm_dp_issue.sv
// Randomized + directed bench for arm_dp_issue; the ALU is emulated from the bench's own
// expectation of operands, and a flag/operand model tracks the architectural state.
module tb_arm_dp_issue;
    localparam int EC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, rn_data, rm_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic        alu_s;
    logic [3:0]  alu_flags;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags_out;
    logic [3:0]  flags;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done, skipped, illegal;

    int checks = 0;
    int failures = 0;

    // model state
    logic [3:0]  m_flags;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_op;
    logic        m_s;
    logic [3:0]  m_af;

    always #5 clk = ~clk;

    arm_dp_issue #(.EXEC_CYCLES(EC)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_instr(instr), .i_rn_data(rn_data),
        .i_rm_data(rm_data), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_s(alu_s),
        .o_alu_flags(alu_flags), .i_alu_result(alu_result), .i_alu_flags_out(alu_flags_out),
        .o_flags(flags), .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .o_done(done), .o_skipped(skipped), .o_illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;           1: return !z;
            2: return cy;          3: return !cy;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cy && !z;    9: return !cy || z;
            10: return n == v;     11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] imm_val(input logic [31:0] ins);
        logic [31:0] v;
        v = {24'b0, ins[7:0]};
`ifdef ARM_DP_ROTATE_IMM_EN
        for (int i = 0; i < 2 * int'(ins[11:8]); i++) v = {v[0], v[31:1]};
`endif
        return v;
    endfunction

    task automatic reset_model();
        m_flags = 4'h0; m_a = 0; m_b = 0; m_op = 5'h10; m_s = 0; m_af = 4'h0;
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] rn,
                       input logic [31:0] rm);
        logic legal, pass, cmp, s;
        logic [3:0]  opc, fo;
        logic [31:0] b, res;
        logic [4:0]  op;
        int k;
        legal = (ins[27:26] == 2'b00) && !(ins[25] == 1'b0 && ins[4] == 1'b1);
        pass  = cond_ok(ins[31:28], m_flags);
        opc   = ins[24:21];
        cmp   = (opc >= 4'd8 && opc <= 4'd11);
        b     = ins[25] ? imm_val(ins) : rm;
        if (opc == 4'd15) b = ~b;
        op    = (opc == 4'd13 || opc == 4'd15) ? 5'h10 : {1'b0, opc};
        s     = ins[20] | cmp;
        case (op)
            5'h10:   res = b;
            5'h02:   res = rn - b;
            5'h04:   res = rn + b;
            5'h0A:   res = rn - b;
            default: res = rn ^ b ^ $urandom;
        endcase
        fo = {res[31], res == 32'd0, 1'($urandom), 1'($urandom)};
        alu_result = res;
        alu_flags_out = fo;

        k = 0;
        while (!instr_ready && k < 20) begin @(negedge clk); k++; end
        chk({tag, ".ready"}, 32'(instr_ready), 32'd1);
        instr = ins; rn_data = rn; rm_data = rm; instr_valid = 1'b1;
        @(posedge clk);
        // Junk offered while busy must be ignored.
        #1 instr = 32'hE3A0F0AA; rn_data = $urandom; rm_data = $urandom;
        @(negedge clk);
        chk({tag, ".c1_done"}, 32'(done), 32'd0);
        chk({tag, ".c1_ready"}, 32'(instr_ready), 32'd0);
        if (!legal || !pass) begin
            instr_valid = 1'b0;
            @(negedge clk);
            chk({tag, ".sk_done"}, 32'(done), 32'd1);
            chk({tag, ".sk_illegal"}, 32'(illegal), 32'(!legal));
            chk({tag, ".sk_skipped"}, 32'(skipped), 32'(legal && !pass));
            chk({tag, ".sk_wb_en"}, 32'(wb_en), 32'd0);
            chk({tag, ".sk_flags"}, 32'(flags), 32'(m_flags));
            chk({tag, ".sk_alu_b_held"}, alu_b, m_b);
            chk({tag, ".sk_alu_op_held"}, 32'(alu_op), 32'(m_op));
            chk({tag, ".sk_ready"}, 32'(instr_ready), 32'd1);
        end else begin
            m_a = rn; m_b = b; m_op = op; m_s = s; m_af = m_flags;
            for (int c = 0; c < EC; c++) begin
                @(negedge clk);
                chk({tag, ".ex_a"}, alu_a, m_a);
                chk({tag, ".ex_b"}, alu_b, m_b);
                chk({tag, ".ex_op"}, 32'(alu_op), 32'(m_op));
                chk({tag, ".ex_s"}, 32'(alu_s), 32'(m_s));
                chk({tag, ".ex_flags"}, 32'(alu_flags), 32'(m_af));
                chk({tag, ".ex_done"}, 32'(done), 32'd0);
            end
            @(negedge clk);
            instr_valid = 1'b0;
            if (s) m_flags = fo;
            chk({tag, ".wb_done"}, 32'(done), 32'd1);
            chk({tag, ".wb_skipped"}, 32'(skipped | illegal), 32'd0);
            chk({tag, ".wb_en"}, 32'(wb_en), 32'(!cmp));
            if (!cmp) begin
                chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(ins[15:12]));
                chk({tag, ".wb_data"}, wb_data, res);
            end
            chk({tag, ".wb_flags"}, 32'(flags), 32'(m_flags));
            chk({tag, ".wb_ready"}, 32'(instr_ready), 32'd0);
            @(negedge clk);
            chk({tag, ".post_ready"}, 32'(instr_ready), 32'd1);
            chk({tag, ".post_done"}, 32'(done | wb_en), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0; instr = 0; rn_data = 0; rm_data = 0; instr_valid = 1'b0;
        alu_result = 0; alu_flags_out = 0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(instr_ready), 32'd1);
        chk("rst.alu_op", 32'(alu_op), 32'h10);
        chk("rst.alu_ab", alu_a | alu_b, 32'd0);
        chk("rst.flags", 32'({flags, alu_flags}), 32'd0);
        chk("rst.strobes", 32'({wb_en, done, skipped, illegal, alu_s}), 32'd0);
        chk("rst.wb", 32'(wb_addr) | wb_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("mov_r1_5", 32'hE3A01005, 32'h0, 32'h0);
        chk("mov_r1_5.flags0", 32'(flags), 32'd0);
        run("subs_eq", 32'hE0502001, 32'd5, 32'd5);
        chk("subs_eq.z", 32'(flags[2]), 32'd1);
        run("addeq", 32'h00803001, 32'd9, 32'd4);
        run("addne", 32'h10803001, 32'd9, 32'd4);
        run("cmp", 32'hE1500001, 32'd7, 32'd3);
        run("ldr", 32'hE5901000, 32'h1234, 32'h5678);
        run("mvn", 32'hE1E04005, 32'h0, 32'h0);
        chk("mvn.all_ones", wb_data, 32'hFFFFFFFF);
        run("mov_rot", 32'hE3A004FF, 32'h0, 32'h0);
`ifdef ARM_DP_ROTATE_IMM_EN
        chk("mov_rot.value", wb_data, 32'hFF000000);
`else
        chk("mov_rot.value", wb_data, 32'h000000FF);
`endif

        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[27:26] = 2'b00;
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            run("rand", ins, $urandom, $urandom);
        end

        // Give FLAGS a nonzero value, then reset in the middle of an ADDS.
        run("subs_neg", 32'hE0502001, 32'd1, 32'd2);
        alu_result = 32'h0; alu_flags_out = 4'hF;
        instr = 32'hE0903001; rn_data = 32'h11; rm_data = 32'h22; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        chk("rst_exec.ready", 32'(instr_ready), 32'd1);
        chk("rst_exec.flags", 32'(flags), 32'd0);
        chk("rst_exec.wb_en", 32'(wb_en), 32'd0);
        chk("rst_exec.done", 32'(done), 32'd0);
        chk("rst_exec.alu_op", 32'(alu_op), 32'h10);
        for (int c = 0; c < EC + 2; c++) begin
            @(negedge clk);
            chk("rst_exec.no_wb", 32'({wb_en, done}), 32'd0);
        end
        run("post_rst_mov", 32'hE3A0700C, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
